// File: rtl/multiword_adder_seq_pkg.sv
// Shared constants, state encoding and width helper for the multi-word adder.
package mwadd_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk-index width: $clog2(words), but never narrower than one bit.
  function automatic int idx_w(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/multiword_adder_seq_if.sv
// Request/result handshake bundle between the operand controller and the adder.
interface multiword_adder_seq_if #(
  parameter int WORDS = 4
);
  import mwadd_pkg::*;

  localparam int W = SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/multiword_adder_seq_cla16_slice.sv
// Combinational 16-bit two-level carry-lookahead adder slice.
module cla16_slice (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c0,
  output logic [15:0] o_s,
  output logic        o_c16
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [3:0]  w_gp;
  logic [3:0]  w_gg;
  logic [4:0]  w_gc;
  logic [15:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // First level: group propagate/generate for each 4-bit group.
  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int i = 0; i < 4; i++) begin
      w_gp[i] = &w_p[4*i +: 4];
      w_gg[i] = w_g[4*i+3]
              | (w_p[4*i+3] & w_g[4*i+2])
              | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
              | (w_p[4*i+3] & w_p[4*i+2] & w_p[4*i+1] & w_g[4*i]);
    end
  end

  // Second level: group carry-ins straight from c0, no ripple between groups.
  always_comb begin
    w_gc    = '0;
    w_gc[0] = i_c0;
    w_gc[1] = w_gg[0] | (w_gp[0] & i_c0);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_c0);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & i_c0);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_c0);
  end

  // Bit carries inside each group, expanded from that group's carry-in.
  always_comb begin
    w_c = '0;
    for (int i = 0; i < 4; i++) begin
      w_c[4*i]   = w_gc[i];
      w_c[4*i+1] = w_g[4*i] | (w_p[4*i] & w_gc[i]);
      w_c[4*i+2] = w_g[4*i+1] | (w_p[4*i+1] & w_g[4*i])
                 | (w_p[4*i+1] & w_p[4*i] & w_gc[i]);
      w_c[4*i+3] = w_g[4*i+2] | (w_p[4*i+2] & w_g[4*i+1])
                 | (w_p[4*i+2] & w_p[4*i+1] & w_g[4*i])
                 | (w_p[4*i+2] & w_p[4*i+1] & w_p[4*i] & w_gc[i]);
    end
  end

  assign o_s   = w_p ^ w_c;
  assign o_c16 = w_gc[4];

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-cycle WORDS x 16-bit add/subtract sharing one CLA slice, LS chunk first.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready=1, waiting for a request
// RUN     | one chunk per cycle through the slice, carry held in r_carry
// DONE    | out_valid=1, result held until out_ready
module multiword_adder_seq
  import mwadd_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multiword_adder_seq_if.slave bus
);

  localparam int W  = SLICE_W * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t         r_state;
  state_t         w_nstate;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic [IW-1:0]  r_idx;

  logic           w_accept;
  logic           w_step;
  logic           w_last;
  logic [15:0]    w_a_chunk;
  logic [15:0]    w_b_chunk;
  logic [15:0]    w_s;
  logic           w_c16;

  assign w_a_chunk = r_a[{r_idx, 4'b0000} +: SLICE_W];
  assign w_b_chunk = r_b[{r_idx, 4'b0000} +: SLICE_W];

  cla16_slice u_slice (
    .i_a   (w_a_chunk),
    .i_b   (w_b_chunk),
    .i_c0  (r_carry),
    .o_s   (w_s),
    .o_c16 (w_c16)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_nstate = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_nstate = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last   = 1'b1;
          w_nstate = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  // Operand capture, per-chunk result write-back and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_idx   <= '0;
    end else if (w_step) begin
      r_sum[{r_idx, 4'b0000} +: SLICE_W] <= w_s;
      r_carry <= w_c16;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c16;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_s[15] != r_a[W-1]);
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed bench for multiword_adder_seq with WORDS=4.
module tb_multiword_adder_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  multiword_adder_seq_if #(.WORDS(4)) bus ();

  multiword_adder_seq #(.WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat=-1 on timeout.
  task automatic run_op(input logic [63:0] ia, input logic [63:0] ib,
                        input logic isub, input logic icin, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    bus.a = ia; bus.b = ib; bus.sub = isub; bus.cin = icin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 64'hDEAD_BEEF_CAFE_F00D; bus.b = 64'h0123_4567_89AB_CDEF;
    bus.sub = ~isub; bus.cin = ~icin;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.sum !== 64'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bus.cout, bus.ovf}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat;
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (bus.sum !== 64'h0000_0000_0001_0000) begin bad++; $display("FAIL basic_sum got=%h exp=0000000000010000", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {bus.cout, bus.ovf}); end
    release_result();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_release got=%b%b exp=01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_full_ripple();
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h0; bus.sub = 1'b0; bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ripple_busy got=%b exp=1", bus.busy); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++; if (dut.r_carry !== 1'b1) begin bad++; $display("FAIL ripple_carry_%0d got=%b exp=1", k, dut.r_carry); end
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ripple_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.sum !== 64'h0) begin bad++; $display("FAIL ripple_sum got=%h exp=0", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b10) begin bad++; $display("FAIL ripple_flags got=%b exp=10", {bus.cout, bus.ovf}); end
    release_result();
  endtask

  task automatic test_subtract();
    int lat;
    run_op(64'd5, 64'd7, 1'b1, 1'b1, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sub57_latency got=%0d exp=4", lat); end
    total++; if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL sub57_sum got=%h exp=FFFFFFFFFFFFFFFE", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b00) begin bad++; $display("FAIL sub57_flags got=%b exp=00", {bus.cout, bus.ovf}); end
    release_result();
    run_op(64'd7, 64'd5, 1'b1, 1'b0, lat);
    total++; if (bus.sum !== 64'd2) begin bad++; $display("FAIL sub75_sum got=%h exp=2", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b10) begin bad++; $display("FAIL sub75_flags got=%b exp=10", {bus.cout, bus.ovf}); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    total++; if (bus.sum !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_add_sum got=%h exp=8000000000000000", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b01) begin bad++; $display("FAIL ovf_add_flags got=%b exp=01", {bus.cout, bus.ovf}); end
    release_result();
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, lat);
    total++; if (bus.sum !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL ovf_sub_sum got=%h exp=7FFFFFFFFFFFFFFF", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b11) begin bad++; $display("FAIL ovf_sub_flags got=%b exp=11", {bus.cout, bus.ovf}); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 1'b0, 1'b0, lat);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        bus.a = 64'hAAAA_AAAA_AAAA_AAAA; bus.b = 64'h5555_5555_5555_5555;
        bus.sub = 1'b1; bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d got=%b%b exp=10", k, bus.out_valid, bus.in_ready); end
      total++; if (bus.sum !== 64'h2345 || {bus.cout, bus.ovf} !== 2'b00) begin bad++; $display("FAIL bp_stable_%0d got=%h/%b exp=2345/00", k, bus.sum, {bus.cout, bus.ovf}); end
    end
    release_result();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b%b exp=10", bus.in_ready, bus.out_valid); end
    run_op(64'h10, 64'h20, 1'b0, 1'b1, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
    total++; if (bus.sum !== 64'h31) begin bad++; $display("FAIL bp_next_sum got=%h exp=31", bus.sum); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.a = 64'h1111_1111_1111_1111; bus.b = 64'h1; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.sum[15:0] !== 16'h1112) begin bad++; $display("FAIL rst_mid_partial got=%h exp=1112", bus.sum[15:0]); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got=%b%b exp=00", bus.out_valid, bus.busy); end
    total++; if (bus.sum !== 64'h0) begin bad++; $display("FAIL rst_mid_sum got=%h exp=0", bus.sum); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=%b%b exp=10", bus.in_ready, bus.out_valid); end
    run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rst_mid_latency got=%0d exp=4", lat); end
    total++; if (bus.sum !== 64'd7) begin bad++; $display("FAIL rst_mid_sum7 got=%h exp=7", bus.sum); end
    release_result();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.sub = 1'b0;
    bus.cin = 1'b0;
    test_reset();
    test_basic_add();
    test_full_ripple();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiword_adder_seq.md
# multiword_adder_seq

Multi-cycle N×16-bit adder/subtractor that time-shares one 16-bit two-level carry-lookahead slice. It adds operands of WORDS 16-bit chunks, least significant chunk first, one chunk per cycle. A registered carry links each chunk to the next. It sits between an operand-issuing controller and the 16-bit CLA datapath, and uses valid/ready handshakes on both the input and the result side.

## Interface
- WORDS, 4, number of 16-bit chunks per operand; legal range 1..8; total width W = 16·WORDS
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept a request
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  0: A+B+cin; 1: A−B, i.e. A+~B+1, and cin is ignored
- cin  input  1  carry-in for add
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- sum  output  W  result, registered
- cout  output  1  carry out of bit W−1; for sub, 1 means no borrow
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Encoding is 2-bit binary.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch a, latch b_eff = sub ? ~b : b, set carry_reg = sub ? 1 : cin, set idx=0, go to RUN.
- RUN:
  - Each cycle the slice computes a_reg[idx·16+:16] + b_eff[idx·16+:16] + carry_reg.
  - The 16-bit result is written into sum[idx·16+:16] and the slice's C16 into carry_reg.
  - idx then increments.
  - When idx==WORDS−1 is processed: cout ← C16, ovf ← (a_msb==b_eff_msb)&&(new sum_msb!=a_msb), go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are held stable.
  - When out_ready: go to IDLE and drop out_valid.
- in_ready=(state==IDLE) only. Requests in RUN/DONE are ignored, not queued.
- The unprocessed upper chunks of sum hold stale data during RUN. sum is only meaningful while out_valid=1.
- Width rules:
  - idx is $clog2(WORDS) bits, minimum 1.
  - For WORDS=1, RUN lasts one cycle.
  - carry_reg is 1 bit.
  - No sign extension is performed; operands are full W bits.
- Reset:
  - Outputs take their reset values immediately: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry_reg=0, busy=0, in_ready=1 (combinational from state).
  - Reset during RUN or DONE aborts the operation. No out_valid is produced for it.

## Timing
- Accept edge E0. out_valid rises at edge E0+WORDS, which is 4 cycles for the default.
- A result is held indefinitely under out_valid&&!out_ready.
- Handshake edge Ek, then IDLE and in_ready=1 at Ek. The next accept is possible at Ek+1.
- Maximum throughput is one operation per WORDS+2 cycles.
- The critical path is one 16-bit CLA slice plus the carry_reg mux. There is no ripple across chunks within a cycle.
- in_valid, a, b, sub and cin are sampled only on the accept edge. They need not be held afterwards.

## Structure
- Shared package mwadd_pkg holds:
  - SLICE_W=16
  - the state encoding localparams ST_IDLE/ST_RUN/ST_DONE
  - the chunk-index width function
- Sub-module cla16_slice is combinational: a[15:0], b[15:0], c0 → s[15:0], c16.
  - It is built from four 4-bit group P/G units plus a second-level lookahead generator.
  - It is instantiated once and driven by the chunk muxes.
- The top module holds the FSM, operand/result registers, carry_reg, idx and the handshake logic.

## Test plan
- Basic add: a=0x0000_0000_0000_FFFF, b=1, sub=0, cin=0 → sum=0x0000_0000_0001_0000, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Also check carry_reg=1 after every RUN cycle.
- Subtract with borrow: a=5, b=7, sub=1, cin=1 (ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also check a=7, b=5 → sum=2, cout=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → sum=0x8000_0000_0000_0000, ovf=1, cout=0. Also check 0x8000…0 − 1 → ovf=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid: sum/cout/ovf stable, in_ready=0, and a pulsed in_valid with other operands is ignored.
  - Then out_ready=1 → in_ready=1 next cycle, and a new accept completes correctly.
- Reset mid-operation: assert rst after 2 RUN cycles → out_valid=0, sum=0, busy=0 asynchronously. After release, in_ready=1 and a fresh add 3+4 returns 7.
